ram_1port_arb: RTL

Two-requester arbiter that shares one single-port RAM (5-bit address, 8-bit data, one shared read/write port) between two independent clients. It sits between the client logic, such as a RAM read/write sequencer, and the single-port RAM IP. It handles grant selection and drives the RAM enable, write-enable, address and write data. It also routes read data back to the client that issued the read, after the fixed RAM read latency.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arb_rd_track.sv | 45 ++++
 rtl/ram_1port_arb.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: default widths, client index
// and the read tag that travels alongside the RAM read latency.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef logic client_id_t;

    typedef struct packed {
        logic       valid;
        client_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/ram_arb_rd_track.sv
// Read-return tracking: delays each read tag by the RAM latency, then registers
// the RAM read data together with the per-client valid so the two line up.
module ram_arb_rd_track
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rd_tag_t           i_tag,
    input  logic [DATA_W-1:0] i_ram_rd_data,
    output logic [1:0]        o_rvalid,
    output logic [DATA_W-1:0] o_rdata
);

    rd_tag_t           r_tag [RD_LAT];
    rd_tag_t           w_tail;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    // The oldest tag meets its RAM data on ram_rd_data in this same cycle.
    assign w_tail = r_tag[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_tag[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_rvalid <= w_tail.valid ? (w_tail.id ? 2'b10 : 2'b01) : 2'b00;
            r_rdata  <= i_ram_rd_data;
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/ram_1port_arb.sv
// Two-client arbiter for one single-port RAM. Round-robin by default; fixed
// priority to client 0 (no last_gnt pointer) when RAM_ARB_STRICT_PRIO_EN is defined.
module ram_1port_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic [1:0] w_gnt_raw;
    client_id_t w_gnt_id;
    rd_tag_t    w_push;

`ifndef RAM_ARB_STRICT_PRIO_EN
    client_id_t r_last_gnt;

    // Resets to client 1 so client 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (|gnt) begin
            r_last_gnt <= w_gnt_id;
        end
    end
`endif

    always_comb begin
        w_gnt_raw = 2'b00;
        case (req)
            2'b01: w_gnt_raw = 2'b01;
            2'b10: w_gnt_raw = 2'b10;
            2'b11: begin
`ifdef RAM_ARB_STRICT_PRIO_EN
                w_gnt_raw = 2'b01;
`else
                w_gnt_raw = r_last_gnt ? 2'b01 : 2'b10;
`endif
            end
            default: w_gnt_raw = 2'b00;
        endcase
    end

    // Grant and everything derived from it are held low while in reset.
    assign gnt      = w_gnt_raw & {2{rst_n}};
    assign w_gnt_id = gnt[1];

    always_comb begin
        ram_en      = |gnt;
        ram_wea     = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        if (gnt[0]) begin
            ram_wea     = we[0];
            ram_addr    = addr0;
            ram_wr_data = wdata0;
        end else if (gnt[1]) begin
            ram_wea     = we[1];
            ram_addr    = addr1;
            ram_wr_data = wdata1;
        end
    end

    always_comb begin
        w_push.valid = ram_en & ~ram_wea;
        w_push.id    = w_gnt_id;
    end

    ram_arb_rd_track #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_track (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tag         (w_push),
        .i_ram_rd_data (ram_rd_data),
        .o_rvalid      (rvalid),
        .o_rdata       (rdata)
    );

endmodule
